hilo_muldiv: RTL and testbench

Multi-cycle multiply/divide unit owning the architectural HI/LO registers. It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the decode stage. The decode stage stalls on a valid/ready handshake and reads HI/LO for MFHI/MFLO once the unit is idle. It sits beside the ALU in the execute stage and generalises datapath width, multiply latency and divider radix.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/hilo_muldiv_if.sv | 26 ++
 rtl/div_iter.sv | 77 +++++++
 rtl/hilo_muldiv.sv | 150 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM
// state type and the divide iteration count helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // DIV_CYCLES depends on module parameters, so it is exposed as a function.
  function automatic int div_cycles(input int width, input int step);
    return width / step;
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Decode-stage <-> multiply/divide unit bundle: issue handshake, flush,
// status and the architectural HI/LO read ports.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  op_ready, busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output op_ready, busy, done, hi, lo
  );
endinterface

// File: rtl/div_iter.sv
// Unsigned restoring divider core: resolves DIV_STEP quotient bits per step
// and flags the final step. Sign handling lives in the caller.
module div_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DIV_STEP = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             last_o
);

  localparam int CYCLES = div_cycles(WIDTH, DIV_STEP);
  localparam int CNT_W  = $clog2(CYCLES);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   trial;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    trial = '0;
    if (start_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
      cnt_d = CNT_W'(CYCLES - 1);
    end else if (step_i) begin
      // The dividend shifts out of quo's MSB while quotient bits shift in at the LSB.
      for (int s = 0; s < DIV_STEP; s++) begin
        trial = {rem_d, quo_d[WIDTH-1]};
        quo_d = {quo_d[WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, dvs_q}) begin
          rem_d    = trial[WIDTH-1:0] - dvs_q;
          quo_d[0] = 1'b1;
        end else begin
          rem_d = trial[WIDTH-1:0];
        end
      end
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: datapath registers are reset as well so nothing stale survives a mid-op reset.
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign last_o      = (cnt_q == '0);

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply/divide unit owning HI/LO: issue FSM, multiply latency
// counter, divide sign handling around div_iter, and the HI/LO registers.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_STEP   = 1
) (
  input  logic           clk,
  input  logic           resetn,
  hilo_muldiv_if.slave   bus
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [1:0]         mcnt_q, mcnt_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;

  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic               div_start, div_step, div_last;
  logic [WIDTH-1:0]   quo, rem;

  assign bus.op_ready = (state_q == ST_IDLE) & ~bus.flush & resetn;
  assign accept       = bus.op_valid & bus.op_ready;

  // Low 2*WIDTH bits of the extended product are exact for signed and unsigned.
  assign a_ext   = {{WIDTH{(bus.op == OP_MULT) & bus.src_a[WIDTH-1]}}, bus.src_a};
  assign b_ext   = {{WIDTH{(bus.op == OP_MULT) & bus.src_b[WIDTH-1]}}, bus.src_b};
  assign product = a_ext * b_ext;

  assign a_neg = (bus.op == OP_DIV) & bus.src_a[WIDTH-1];
  assign b_neg = (bus.op == OP_DIV) & bus.src_b[WIDTH-1];
  assign a_mag = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag = b_neg ? -bus.src_b : bus.src_b;

  div_iter #(
    .WIDTH    (WIDTH),
    .DIV_STEP (DIV_STEP)
  ) u_div (
    .clk         (clk),
    .resetn      (resetn),
    .start_i     (div_start),
    .step_i      (div_step),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .quotient_o  (quo),
    .remainder_o (rem),
    .last_o      (div_last)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    prod_d    = prod_q;
    mcnt_d    = mcnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    div_start = 1'b0;
    div_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (bus.op)
            OP_MTHI: hi_d = bus.src_a;
            OP_MTLO: lo_d = bus.src_a;
            OP_MULT, OP_MULTU: begin
              prod_d  = product;
              mcnt_d  = 2'(MUL_STAGES - 1);
              state_d = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              div_start = 1'b1;
              // A zero divisor keeps the quotient unsigned, so all-ones falls out.
              qneg_d  = (a_neg ^ b_neg) & (|bus.src_b);
              rneg_d  = a_neg;
              state_d = ST_DIV;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (mcnt_q == 2'd0) begin
          {hi_d, lo_d} = prod_q;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          mcnt_d = mcnt_q - 2'd1;
        end
      end
      ST_DIV: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          div_step = 1'b1;
          if (div_last) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!bus.flush) begin
          lo_d   = qneg_q ? -quo : quo;
          hi_d   = rneg_q ? -rem : rem;
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      prod_q  <= '0;
      mcnt_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
      mcnt_q  <= mcnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: a radix-2 and a radix-4 divider instance
// share stimulus; sel routes issue to one of them at a time.
module tb_hilo_muldiv;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         sel = 1'b0;
  logic         op_valid = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         flush = 1'b0;

  hilo_muldiv_if #(.WIDTH(W)) bus1 ();
  hilo_muldiv_if #(.WIDTH(W)) bus2 ();

  assign bus1.op_valid = op_valid & ~sel;
  assign bus2.op_valid = op_valid & sel;
  assign bus1.op = op;     assign bus2.op = op;
  assign bus1.src_a = src_a; assign bus2.src_a = src_a;
  assign bus1.src_b = src_b; assign bus2.src_b = src_b;
  assign bus1.flush = flush; assign bus2.flush = flush;

  hilo_muldiv #(.WIDTH(W), .MUL_STAGES(2), .DIV_STEP(1)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1));
  hilo_muldiv #(.WIDTH(W), .MUL_STAGES(2), .DIV_STEP(2)) dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2));

  logic         rdy_m, busy_m, done_m;
  logic [W-1:0] hi_m, lo_m;
  assign rdy_m  = sel ? bus2.op_ready : bus1.op_ready;
  assign busy_m = sel ? bus2.busy : bus1.busy;
  assign done_m = sel ? bus2.done : bus1.done;
  assign hi_m   = sel ? bus2.hi : bus1.hi;
  assign lo_m   = sel ? bus2.lo : bus1.lo;

  always #5 clk = ~clk;

  int cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (busy_m) busy_cnt <= busy_cnt + 1;
    if (resetn && done_m) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           acc;
    int           lat;
    int           busy0;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;
  int last_acc = 0;
  int last_busy0 = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint sa, sb2, q, r;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    case (o)
      OP_MULT:  return sa * sb2;
      OP_MULTU: return {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb2;
        r = sa % sb2;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int i = 0;
    while (!rdy_m && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("ready_wait", 64'(rdy_m), 64'd1);
    op = o; src_a = a; src_b = b; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid   = 1'b0;
    last_acc   = cyc;
    last_busy0 = busy_cnt;
  endtask

  task automatic start_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input int lat);
    exp_t e;
    send(o, a, b);
    e.tag = tag; e.hi = eh; e.lo = el; e.lat = lat;
    e.acc = last_acc; e.busy0 = last_busy0;
    sb.push_back(e);
  endtask

  task automatic finish_op();
    exp_t e;
    bit   got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (done_m) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(got), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (got) begin
        check({e.tag, "_hi"}, 64'(hi_m), 64'(e.hi));
        check({e.tag, "_lo"}, 64'(lo_m), 64'(e.lo));
        check({e.tag, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
        check({e.tag, "_busy"}, 64'(busy_cnt - e.busy0), 64'(e.lat));
      end
    end
    @(negedge clk);
    #1;
    check("done_pulse_width", 64'(done_m), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input int lat);
    start_op(tag, o, a, b, eh, el, lat);
    finish_op();
  endtask

  task automatic run_model(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int lat);
    logic [63:0] m;
    m = model(o, a, b);
    run_op(tag, o, a, b, m[63:32], m[31:0], lat);
  endtask

  task automatic mul_suite();
    run_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 2);
    for (int i = 0; i < 3; i++) begin
      run_model("mult_rnd", OP_MULT, $urandom, $urandom, 2);
      run_model("multu_rnd", OP_MULTU, $urandom, $urandom, 2);
    end
  endtask

  task automatic div_suite(input int lat);
    run_op("div_neg7", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, lat);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, lat);
    run_op("divu_zero", OP_DIVU, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, lat);
    run_op("div_zero", OP_DIV, 32'h8000_0005, 32'h0, 32'h8000_0005, 32'hFFFF_FFFF, lat);
    run_op("divu_one", OP_DIVU, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'hFFFF_FFFF, lat);
    for (int i = 0; i < 3; i++) begin
      run_model("div_rnd", OP_DIV, $urandom, $urandom_range(1, 1000) * (i == 1 ? -1 : 1), lat);
      run_model("divu_rnd", OP_DIVU, $urandom, $urandom_range(1, 70000), lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] prev_hi, prev_lo;
    int           snap;

    #12;
    check("rst_ready", 64'(rdy_m), 64'd0);
    check("rst_ready2", 64'(bus2.op_ready), 64'd0);
    check("rst_busy", 64'(busy_m), 64'd0);
    check("rst_done", 64'(done_m), 64'd0);
    check("rst_hi", 64'(hi_m), 64'd0);
    check("rst_lo", 64'(lo_m), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post_rst_ready", 64'(rdy_m), 64'd1);

    mul_suite();
    div_suite(33);

    // MTHI is immediate and never busy.
    send(OP_MTHI, 32'hA5A5_A5A5, 32'h0);
    check("mthi_hi", 64'(hi_m), 64'hA5A5_A5A5);
    check("mthi_busy", 64'(busy_m), 64'd0);
    @(negedge clk);
    #1;
    check("mthi_no_done", 64'(done_m), 64'd0);

    // Flush a divide at cycle 10.
    prev_lo = lo_m;
    snap = done_cnt;
    send(OP_DIV, 32'd100, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    #1;
    check("flush_busy", 64'(busy_m), 64'd0);
    check("flush_ready", 64'(rdy_m), 64'd1);
    check("flush_hi", 64'(hi_m), 64'hA5A5_A5A5);
    repeat (40) @(negedge clk);
    #1;
    check("flush_no_done", 64'(done_cnt - snap), 64'd0);
    check("flush_lo", 64'(lo_m), 64'(prev_lo));

    // Flush while idle blocks even MTLO.
    @(negedge clk);
    flush = 1'b1; op = OP_MTLO; src_a = 32'hDEAD_BEEF; op_valid = 1'b1;
    #1;
    check("idle_flush_ready", 64'(rdy_m), 64'd0);
    @(posedge clk);
    #1;
    op_valid = 1'b0; flush = 1'b0;
    check("idle_flush_lo", 64'(lo_m), 64'(prev_lo));

    // MTLO offered while a divide is in flight is refused.
    start_op("divu_busy", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    op = OP_MTLO; src_a = 32'hDEAD_BEEF; op_valid = 1'b1;
    @(negedge clk);
    #1;
    check("busy_mtlo_ready", 64'(rdy_m), 64'd0);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    check("busy_mtlo_lo", 64'(lo_m), 64'(prev_lo));
    finish_op();

    // Flush in the cycle ending at the multiply completion edge.
    prev_hi = hi_m;
    prev_lo = lo_m;
    snap = done_cnt;
    send(OP_MULT, 32'd3, 32'd5);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    #1;
    check("cflush_hi", 64'(hi_m), 64'(prev_hi));
    check("cflush_lo", 64'(lo_m), 64'(prev_lo));
    check("cflush_busy", 64'(busy_m), 64'd0);
    check("cflush_no_done", 64'(done_cnt - snap), 64'd0);

    // Asynchronous reset in the middle of a multiply.
    snap = done_cnt;
    send(OP_MULT, 32'd7, 32'd9);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_hi", 64'(hi_m), 64'd0);
    check("arst_lo", 64'(lo_m), 64'd0);
    check("arst_busy", 64'(busy_m), 64'd0);
    check("arst_ready", 64'(rdy_m), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("arst_after_hi", 64'(hi_m), 64'd0);
    check("arst_after_busy", 64'(busy_m), 64'd0);
    check("arst_no_done", 64'(done_cnt - snap), 64'd0);

    // Radix-4 divider instance.
    @(negedge clk);
    sel = 1'b1;
    #1;
    mul_suite();
    div_suite(17);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
